// File: rtl/div_seq_pkg.sv
// Shared widths and FSM state encodings for the sequential divider.
package div_seq_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Iteration counter width: clog2(XLEN), never narrower than one bit.
    function automatic int cnt_width(input int xlen);
        return (xlen > 1) ? $clog2(xlen) : 1;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division iteration: shift in the dividend MSB, trial-subtract the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] r,
    input  logic            msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] r_next,
    output logic            q_bit
);

    logic [XLEN:0]   r_shift;
    logic [XLEN-1:0] r_diff;

    always_comb begin
        r_shift = {r, msb};
        // True difference is below 2^XLEN whenever it is selected, so modular subtraction suffices.
        r_diff  = r_shift[XLEN-1:0] - divisor;
        q_bit   = (r_shift >= {1'b0, divisor});
        r_next  = q_bit ? r_diff : r_shift[XLEN-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// Unsigned radix-2 restoring divider, XLEN+1 cycles per request; abort by dropping req_i while busy.
// Optional DIV_EARLY_OUT_EN: b = 0 or a < b completes in one cycle with identical results.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = DATA_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            is_q_i,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = cnt_width(XLEN);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvd;      // dividend shifts out the top while quotient bits shift in below
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic            is_q;

    logic [XLEN-1:0] r_next;
    logic            q_bit;
    logic [XLEN-1:0] q_next;

    div_step #(.XLEN(XLEN)) u_step (
        .r       (rem),
        .msb     (dvd[XLEN-1]),
        .divisor (dvs),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    assign q_next  = {dvd[XLEN-2:0], q_bit};
    assign ready_o = (state == DIV_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            is_q     <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (req_i) begin
                        dvd   <= a_i;
                        dvs   <= b_i;
                        is_q  <= is_q_i;
                        rem   <= '0;
                        cnt   <= CW'(XLEN - 1);
                        state <= DIV_BUSY;
`ifdef DIV_EARLY_OUT_EN
                        if ((b_i == '0) || (a_i < b_i)) begin
                            rem      <= a_i;
                            dvd      <= (b_i == '0) ? '1 : '0;
                            result_o <= is_q_i ? ((b_i == '0) ? '1 : '0) : a_i;
                            state    <= DIV_DONE;
                        end
`endif
                    end
                end
                DIV_BUSY: begin
                    if (!req_i) begin
                        state <= DIV_IDLE;
                    end else begin
                        dvd <= q_next;
                        rem <= r_next;
                        if (cnt == '0) begin
                            result_o <= is_q ? q_next : r_next;
                            state    <= DIV_DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

endmodule
